ex_stage_pip: RTL and testbench
===============================

# ex_stage_pip

Execute stage of the five-stage RV32I pipeline. It sits between the ID/EX register and the memory stage. It selects forwarded operands, runs the ALU, and resolves branches and jumps combinationally. Its results go into an internal EX/MEM pipeline register whose outputs drive the memory stage directly, with stall (hold) and flush (bubble) control.

## Interface
Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  hold the EX/MEM register and suppress redirect.
- flush  in  1  load a bubble into the EX/MEM register.
- pc_in  in  32  instruction PC.
- rs1_data_in, rs2_data_in  in  32  register-file operands from ID/EX.
- imm_in  in  32  sign-extended immediate.
- funct3_in  in  3  branch condition and load/store size.
- rd_in  in  5  destination register.
- alu_op_in  in  4  ALU operation, encoded per ex_pkg.
- alu_src_a_in  in  2  A source: 0 = rs1, 1 = pc, 2 = zero.
- alu_src_b_in  in  1  B source: 0 = rs2, 1 = imm.
- branch_in, jump_in, jalr_in  in  1 each  control-flow class.
- wb_sel_in  in  2  writeback select, passed through.
- mem_read_in, mem_write_in, reg_write_in, mem_to_reg_in  in  1 each  control, passed through.
- fwd_a_sel, fwd_b_sel  in  2 each  forwarding select: 0 = regfile, 1 = fwd_mem_data, 2 = fwd_wb_data, 3 = regfile.
- fwd_mem_data, fwd_wb_data  in  32 each  forwarded results.
- branch_taken_out  out  1  redirect request (combinational).
- branch_target_out  out  32  redirect PC (combinational).
- pc_out, alu_result_out, rs2_data_out  out  32 each  registered.
- funct3_out  out  3  registered.
- rd_out  out  5  registered.
- wb_sel_out  out  2  registered.
- mem_read_out, mem_write_out, reg_write_out, mem_to_reg_out  out  1 each  registered.

## Operation
- Forwarded operands:
  - fa = mux(fwd_a_sel, rs1_data_in, fwd_mem_data, fwd_wb_data).
  - fb is the same selection built from rs2_data_in.
- ALU inputs:
  - A = fa, pc_in or 0, per alu_src_a_in.
  - B = fb or imm_in, per alu_src_b_in.
- ALU operations: ADD, SUB, SLL, SLT (signed), SLTU, XOR, SRL, SRA, OR, AND, PASSB.
  - Shift amount is B[4:0].
  - SLT/SLTU return 0 or 1, zero-extended.
  - Arithmetic is modulo 2^32 with no overflow flag.
  - Undefined alu_op values return 0.
- Branch conditions on fa/fb, by funct3:
  - 000 BEQ, 001 BNE, 100 BLT, 101 BGE (signed).
  - 110 BLTU, 111 BGEU (unsigned).
  - 010/011 never taken.
- branch_taken_out = !stall & (jump_in | (branch_in & cond)).
- branch_target_out:
  - jalr_in: (fa + imm_in) & ~1.
  - otherwise: pc_in + imm_in.
  - No misalignment check.
- Store data is rs2_data_out = fb, i.e. forwarding applies to store data.
- EX/MEM register update priority: rst > flush > stall > load.
  - rst low: every registered output is 0 (bubble).
  - flush: every registered output is cleared to 0, so the slot becomes a NOP.
  - stall without flush: all registered outputs hold.
  - otherwise: load ALU result, fb, pc_in, funct3_in, rd_in, wb_sel_in and the four control bits.
- Simultaneous flush and stall: flush wins.

## Timing
- ALU and branch paths are combinational from inputs to the register D side and to branch_* outputs.
- Latency is one cycle: the instruction present at edge N appears on the registered outputs after edge N.
- branch_taken_out is valid in the same cycle the instruction is in EX. The front end must flush IF/ID and ID/EX on it.
- branch_taken_out is 0 whenever stall is high, so a held instruction redirects exactly once, in the cycle it advances.
- Reset is asynchronous on assertion. It must be deasserted synchronously to clk externally.
- Reset mid-operation discards the in-flight EX/MEM contents.
- During reset branch_taken_out is still computed from inputs; the fetch stage ignores it while in reset.

## Structure
- ex_pkg holds:
  - the ALU op constants: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASSB=10;
  - the funct3 branch codes;
  - the forwarding-select codes.
- One sub-module, alu (combinational: a, b, op -> result), is instantiated here.
- Branch compare, forwarding and the EX/MEM register stay inline.

## Test plan
- Reset and bubble:
  - Drive rst low mid-stream -> all registered outputs 0 immediately.
  - With alu_op=ADD, rs1=5, imm=7, alu_src_b=1: the first edge after release gives alu_result_out=12.
- ALU coverage:
  - SUB 3-5 -> 0xFFFFFFFE.
  - SRA 0x80000000>>4 -> 0xF8000000.
  - SLT(-1,1)=1; SLTU(-1,1)=0.
  - PASSB imm=0x12345000 -> 0x12345000.
- Forwarding:
  - rs1_data=1, fwd_a_sel=1, fwd_mem_data=100, ADD imm 4 -> 104.
  - Store with fwd_b_sel=2, fwd_wb_data=0xDEADBEEF -> rs2_data_out=0xDEADBEEF.
- Branches:
  - BLT fa=-2, fb=1, pc=0x100, imm=0x20 -> taken, target 0x120.
  - BGEU same operands -> taken.
  - BNE with equal operands -> not taken.
  - JALR fa=0x203, imm=0 -> target 0x202.
- Stall/flush:
  - Stall for 3 cycles -> outputs hold and branch_taken_out=0 throughout.
  - Assert flush and stall together -> reg_write_out=0, mem_write_out=0, rd_out=0.
  - Release -> the next instruction loads.

Source files
------------

// File: rtl/ex_pkg.sv
// ex_pkg: shared constants and types for the RV32I execute stage
package ex_pkg;
   localparam logic [3:0] ALU_ADD   = 4'd0;
   localparam logic [3:0] ALU_SUB   = 4'd1;
   localparam logic [3:0] ALU_SLL   = 4'd2;
   localparam logic [3:0] ALU_SLT   = 4'd3;
   localparam logic [3:0] ALU_SLTU  = 4'd4;
   localparam logic [3:0] ALU_XOR   = 4'd5;
   localparam logic [3:0] ALU_SRL   = 4'd6;
   localparam logic [3:0] ALU_SRA   = 4'd7;
   localparam logic [3:0] ALU_OR    = 4'd8;
   localparam logic [3:0] ALU_AND   = 4'd9;
   localparam logic [3:0] ALU_PASSB = 4'd10;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [1:0] FWD_RF  = 2'd0;
   localparam logic [1:0] FWD_MEM = 2'd1;
   localparam logic [1:0] FWD_WB  = 2'd2;

   localparam logic [1:0] SRC_A_RS1  = 2'd0;
   localparam logic [1:0] SRC_A_PC   = 2'd1;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] alu_result;
      logic [31:0] rs2_data;
      logic [2:0]  funct3;
      logic [4:0]  rd;
      logic [1:0]  wb_sel;
      logic        mem_read;
      logic        mem_write;
      logic        reg_write;
      logic        mem_to_reg;
   } exmem_t;

   // codes 0 and 3 both fall back to the register-file value
   function automatic logic [31:0] fwd_pick(logic [1:0] sel, logic [31:0] rf, logic [31:0] mem, logic [31:0] wb);
      return sel == FWD_MEM ? mem : sel == FWD_WB ? wb : rf;
   endfunction
endpackage

// File: rtl/ex_stage_pip_alu.sv
// alu: combinational RV32I integer ALU, undefined ops yield zero
module alu
   import ex_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [3:0]  op,
   output logic [31:0] result
);
   logic [4:0] sh;
   assign sh = b[4:0];
   // operation select
   always_comb begin
      result = '0;
      case (op)
         ALU_ADD:   result = a + b;
         ALU_SUB:   result = a - b;
         ALU_SLL:   result = a << sh;
         ALU_SLT:   result = {31'd0, $signed(a) < $signed(b)};
         ALU_SLTU:  result = {31'd0, a < b};
         ALU_XOR:   result = a ^ b;
         ALU_SRL:   result = a >> sh;
         ALU_SRA:   result = $unsigned($signed(a) >>> sh);
         ALU_OR:    result = a | b;
         ALU_AND:   result = a & b;
         ALU_PASSB: result = b;
         default:   result = '0;
      endcase
   end
endmodule

// File: rtl/ex_stage_pip.sv
// ex_stage_pip: RV32I execute stage with forwarding, branch resolve and EX/MEM register
module ex_stage_pip
   import ex_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            flush,
   input  logic [XLEN-1:0] pc_in,
   input  logic [XLEN-1:0] rs1_data_in,
   input  logic [XLEN-1:0] rs2_data_in,
   input  logic [XLEN-1:0] imm_in,
   input  logic [2:0]      funct3_in,
   input  logic [4:0]      rd_in,
   input  logic [3:0]      alu_op_in,
   input  logic [1:0]      alu_src_a_in,
   input  logic            alu_src_b_in,
   input  logic            branch_in,
   input  logic            jump_in,
   input  logic            jalr_in,
   input  logic [1:0]      wb_sel_in,
   input  logic            mem_read_in,
   input  logic            mem_write_in,
   input  logic            reg_write_in,
   input  logic            mem_to_reg_in,
   input  logic [1:0]      fwd_a_sel,
   input  logic [1:0]      fwd_b_sel,
   input  logic [XLEN-1:0] fwd_mem_data,
   input  logic [XLEN-1:0] fwd_wb_data,
   output logic            branch_taken_out,
   output logic [XLEN-1:0] branch_target_out,
   output logic [XLEN-1:0] pc_out,
   output logic [XLEN-1:0] alu_result_out,
   output logic [XLEN-1:0] rs2_data_out,
   output logic [2:0]      funct3_out,
   output logic [4:0]      rd_out,
   output logic [1:0]      wb_sel_out,
   output logic            mem_read_out,
   output logic            mem_write_out,
   output logic            reg_write_out,
   output logic            mem_to_reg_out
);
   logic [31:0] fa, fb, op_a, op_b, alu_y;
   logic        eq, lt, ltu, cond;
   exmem_t      d, q;

   assign fa   = fwd_pick(fwd_a_sel, rs1_data_in, fwd_mem_data, fwd_wb_data);
   assign fb   = fwd_pick(fwd_b_sel, rs2_data_in, fwd_mem_data, fwd_wb_data);
   assign op_a = alu_src_a_in == SRC_A_RS1 ? fa : alu_src_a_in == SRC_A_PC ? pc_in : '0;
   assign op_b = alu_src_b_in ? imm_in : fb;

   alu u_alu (
      .a      (op_a),
      .b      (op_b),
      .op     (alu_op_in),
      .result (alu_y)
   );

   assign eq  = fa == fb;
   assign lt  = $signed(fa) < $signed(fb);
   assign ltu = fa < fb;
   assign cond = funct3_in == F3_BEQ  ? eq   :
                 funct3_in == F3_BNE  ? !eq  :
                 funct3_in == F3_BLT  ? lt   :
                 funct3_in == F3_BGE  ? !lt  :
                 funct3_in == F3_BLTU ? ltu  :
                 funct3_in == F3_BGEU ? !ltu : 1'b0;

   assign branch_taken_out  = !stall & (jump_in | (branch_in & cond));
   assign branch_target_out = jalr_in ? (fa + imm_in) & ~32'd1 : pc_in + imm_in;

   assign d = '{pc: pc_in, alu_result: alu_y, rs2_data: fb, funct3: funct3_in, rd: rd_in,
                wb_sel: wb_sel_in, mem_read: mem_read_in, mem_write: mem_write_in,
                reg_write: reg_write_in, mem_to_reg: mem_to_reg_in};

   // EX/MEM register: reset and flush insert a bubble, stall holds
   always_ff @(posedge clk or negedge rst)
      if (!rst) q <= '0;
      else if (flush) q <= '0;
      else if (!stall) q <= d;

   assign pc_out         = q.pc;
   assign alu_result_out = q.alu_result;
   assign rs2_data_out   = q.rs2_data;
   assign funct3_out     = q.funct3;
   assign rd_out         = q.rd;
   assign wb_sel_out     = q.wb_sel;
   assign mem_read_out   = q.mem_read;
   assign mem_write_out  = q.mem_write;
   assign reg_write_out  = q.reg_write;
   assign mem_to_reg_out = q.mem_to_reg;
endmodule

// File: tb/tb_ex_stage_pip.sv
// tb_ex_stage_pip: directed scoreboard bench for the execute stage
module tb_ex_stage_pip;
   logic        clk = 0, rst = 0, stall = 0, flush = 0;
   logic [31:0] pc, rs1, rs2, imm, fmd, fwd;
   logic [2:0]  f3;
   logic [4:0]  rd;
   logic [3:0]  op;
   logic [1:0]  sa, wb, fas, fbs;
   logic        sbi, br, jmp, jalr, mr, mw, rw, mtr;
   logic        taken;
   logic [31:0] target, pc_o, alu_o, rs2_o;
   logic [2:0]  f3_o;
   logic [4:0]  rd_o;
   logic [1:0]  wb_o;
   logic        mr_o, mw_o, rw_o, mtr_o;

   typedef struct packed {
      logic [31:0] alu;
      logic [31:0] rs2;
      logic [31:0] pc;
      logic [31:0] ctl;
   } exp_t;

   exp_t scb[$];
   exp_t last;
   int   errors = 0, checks = 0;

   always #5 clk = ~clk;

   ex_stage_pip dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .pc_in(pc), .rs1_data_in(rs1), .rs2_data_in(rs2), .imm_in(imm),
      .funct3_in(f3), .rd_in(rd), .alu_op_in(op), .alu_src_a_in(sa), .alu_src_b_in(sbi),
      .branch_in(br), .jump_in(jmp), .jalr_in(jalr), .wb_sel_in(wb),
      .mem_read_in(mr), .mem_write_in(mw), .reg_write_in(rw), .mem_to_reg_in(mtr),
      .fwd_a_sel(fas), .fwd_b_sel(fbs), .fwd_mem_data(fmd), .fwd_wb_data(fwd),
      .branch_taken_out(taken), .branch_target_out(target),
      .pc_out(pc_o), .alu_result_out(alu_o), .rs2_data_out(rs2_o),
      .funct3_out(f3_o), .rd_out(rd_o), .wb_sel_out(wb_o),
      .mem_read_out(mr_o), .mem_write_out(mw_o), .reg_write_out(rw_o), .mem_to_reg_out(mtr_o)
   );

   function automatic logic [31:0] ctl(logic [2:0] f, logic [4:0] r, logic [1:0] w,
                                       logic a, logic b, logic c, logic d);
      return {18'd0, f, r, w, a, b, c, d};
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_regs(string tag, exp_t e);
      chk({tag, ".alu"}, alu_o, e.alu);
      chk({tag, ".rs2"}, rs2_o, e.rs2);
      chk({tag, ".pc"}, pc_o, e.pc);
      chk({tag, ".ctl"}, ctl(f3_o, rd_o, wb_o, mr_o, mw_o, rw_o, mtr_o), e.ctl);
   endtask

   task automatic clr();
      {pc, rs1, rs2, imm, fmd, fwd} = '0;
      {f3, rd, op, sa, wb, fas, fbs} = '0;
      {sbi, br, jmp, jalr, mr, mw, rw, mtr} = '0;
   endtask

   task automatic push(logic [31:0] a, logic [31:0] r2, logic [31:0] p, logic [31:0] c);
      scb.push_back('{alu: a, rs2: r2, pc: p, ctl: c});
   endtask

   task automatic tick(string tag);
      @(posedge clk);
      #1;
      checks++;
      assert (scb.size() > 0) else begin
         errors++;
         $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
      end
      if (scb.size() > 0) begin
         last = scb.pop_front();
         chk_regs(tag, last);
      end
   endtask

   initial begin
      clr();
      repeat (2) @(posedge clk);
      #1;
      chk_regs("reset", '0);
      @(negedge clk);
      rst = 1;
      // ADD 5+7 right after release
      clr(); op = 0; rs1 = 5; imm = 7; sbi = 1; rd = 3; rw = 1; wb = 1; pc = 32'h40;
      push(12, 0, 32'h40, ctl(0, 3, 1, 0, 0, 1, 0));
      tick("add");
      clr(); op = 1; rs1 = 3; rs2 = 5; rd = 4; rw = 1; pc = 32'h44;
      push(32'hFFFFFFFE, 5, 32'h44, ctl(0, 4, 0, 0, 0, 1, 0));
      tick("sub");
      clr(); op = 7; rs1 = 32'h80000000; imm = 4; sbi = 1; pc = 32'h48;
      push(32'hF8000000, 0, 32'h48, 0);
      tick("sra");
      clr(); op = 3; rs1 = 32'hFFFFFFFF; imm = 1; sbi = 1;
      push(1, 0, 0, 0);
      tick("slt");
      clr(); op = 4; rs1 = 32'hFFFFFFFF; imm = 1; sbi = 1;
      push(0, 0, 0, 0);
      tick("sltu");
      clr(); op = 10; imm = 32'h12345000; sbi = 1; rs1 = 32'h55;
      push(32'h12345000, 0, 0, 0);
      tick("passb");
      clr(); op = 15; rs1 = 9; rs2 = 9;
      push(0, 9, 0, 0);
      tick("undef_op");
      clr(); op = 0; rs1 = 1; fas = 1; fmd = 100; imm = 4; sbi = 1; rd = 7; rw = 1;
      push(104, 0, 0, ctl(0, 7, 0, 0, 0, 1, 0));
      tick("fwd_a_mem");
      clr(); op = 0; rs1 = 32'h1000; imm = 8; sbi = 1; rs2 = 32'h11; fbs = 2; fwd = 32'hDEADBEEF;
      mw = 1; f3 = 3'b010;
      push(32'h1008, 32'hDEADBEEF, 0, ctl(3'b010, 0, 0, 0, 1, 0, 0));
      tick("store_fwd_wb");
      // BLT -2 < 1
      clr(); op = 1; rs1 = 32'hFFFFFFFE; rs2 = 1; pc = 32'h100; imm = 32'h20; br = 1; f3 = 3'b100;
      #1;
      chk("blt.taken", {31'd0, taken}, 1);
      chk("blt.target", target, 32'h120);
      push(32'hFFFFFFFD, 1, 32'h100, ctl(3'b100, 0, 0, 0, 0, 0, 0));
      tick("blt");
      f3 = 3'b111;
      #1;
      chk("bgeu.taken", {31'd0, taken}, 1);
      f3 = 3'b101;
      #1;
      chk("bge.taken", {31'd0, taken}, 0);
      f3 = 3'b011;
      #1;
      chk("f3_011.taken", {31'd0, taken}, 0);
      clr(); rs1 = 7; rs2 = 7; br = 1; f3 = 3'b001;
      #1;
      chk("bne_eq.taken", {31'd0, taken}, 0);
      f3 = 3'b000;
      #1;
      chk("beq_eq.taken", {31'd0, taken}, 1);
      // JALR
      clr(); jmp = 1; jalr = 1; rs1 = 32'h203; pc = 32'h300; sa = 1; sbi = 1; rd = 1; rw = 1;
      #1;
      chk("jalr.taken", {31'd0, taken}, 1);
      chk("jalr.target", target, 32'h202);
      push(32'h300, 0, 32'h300, ctl(0, 1, 0, 0, 0, 1, 0));
      tick("jalr");
      // stall holds for 3 cycles
      clr(); op = 0; rs1 = 20; imm = 22; sbi = 1; rd = 5; rw = 1; mr = 1; mtr = 1; wb = 2; pc = 32'h500;
      push(42, 0, 32'h500, ctl(0, 5, 2, 1, 0, 1, 1));
      tick("pre_stall");
      clr(); op = 5; rs1 = 32'hFF; imm = 32'h0F; sbi = 1; jmp = 1; pc = 32'h600; rd = 6; rw = 1;
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall.taken", {31'd0, taken}, 0);
         @(posedge clk);
         #1;
         chk_regs("stall_hold", last);
      end
      stall = 0;
      #1;
      chk("unstall.taken", {31'd0, taken}, 1);
      push(32'hF0, 0, 32'h600, ctl(0, 6, 0, 0, 0, 1, 0));
      tick("unstall");
      // flush beats stall
      clr(); op = 0; rs1 = 1; rd = 9; rw = 1; mw = 1; pc = 32'h700;
      flush = 1; stall = 1;
      push(0, 0, 0, 0);
      tick("flush_stall");
      flush = 0; stall = 0;
      clr(); op = 8; rs1 = 32'hF0; rs2 = 32'h0F; rd = 10; rw = 1; pc = 32'h704;
      push(32'hFF, 32'h0F, 32'h704, ctl(0, 10, 0, 0, 0, 1, 0));
      tick("after_flush");
      // asynchronous reset mid-stream
      #2;
      rst = 0;
      #1;
      chk_regs("async_reset", '0);
      @(negedge clk);
      rst = 1;
      clr(); op = 0; rs1 = 5; imm = 7; sbi = 1;
      push(12, 0, 0, 0);
      tick("post_reset_add");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
